// File: rtl/spi_ram_cmd.sv
// spi_ram_cmd: command-decoding single-port RAM behind an SPI slave.
// Each 10-bit word on din/rx_valid carries a 2-bit opcode and an 8-bit payload.
// The opcodes load the write/read address pointers or move one data byte.
// The write and read pointers are kept separately and both auto-increment.
// Read data is returned on dout/tx_valid for the slave to shift out next frame.
module spi_ram_cmd #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] din,
   input  logic       rx_valid,
   output logic [7:0] dout,
   output logic       tx_valid,
   output logic       seq_err
);

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } opcode_t;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } tx_state_t;

   logic [7:0]           mem [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] wr_ptr;
   logic [ADDR_SIZE-1:0] rd_ptr;
   logic                 wr_loaded;
   logic                 rd_loaded;
   tx_state_t            state;
   opcode_t              opcode;
   logic                 wr_accept;
   logic                 rd_accept;

   // Decode the opcode and the accept qualifiers for the data commands.
   always_comb begin
      opcode    = opcode_t'(din[9:8]);
      wr_accept = rx_valid && (opcode == OP_WR_DATA) && wr_loaded;
      rd_accept = rx_valid && (opcode == OP_RD_DATA) && rd_loaded;
   end

   // Storage array: an accepted write is dropped when reset is asserted on the same edge.
   always_ff @(posedge clk) begin
      if (!rst && wr_accept) begin
         mem[wr_ptr] <= din[7:0];
      end
   end

   // Pointers, load flags, the tx_valid FSM and the registered read/error outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         wr_loaded <= 1'b0;
         rd_loaded <= 1'b0;
         state     <= EMPTY;
         tx_valid  <= 1'b0;
         dout      <= '0;
         seq_err   <= 1'b0;
      end else begin
         seq_err <= 1'b0;
         if (rx_valid) begin
            unique case (opcode)
               OP_WR_ADDR: begin
                  wr_ptr    <= din[ADDR_SIZE-1:0];
                  wr_loaded <= 1'b1;
                  state     <= EMPTY;
                  tx_valid  <= 1'b0;
               end
               OP_WR_DATA: begin
                  if (wr_loaded) begin
                     wr_ptr <= wr_ptr + ADDR_SIZE'(1);
                  end else begin
                     seq_err <= 1'b1;
                  end
                  state    <= EMPTY;
                  tx_valid <= 1'b0;
               end
               OP_RD_ADDR: begin
                  rd_ptr    <= din[ADDR_SIZE-1:0];
                  rd_loaded <= 1'b1;
                  state     <= EMPTY;
                  tx_valid  <= 1'b0;
               end
               OP_RD_DATA: begin
                  if (rd_accept) begin
                     dout     <= mem[rd_ptr];
                     rd_ptr   <= rd_ptr + ADDR_SIZE'(1);
                     state    <= HOLD;
                     tx_valid <= 1'b1;
                  end else begin
                     seq_err  <= 1'b1;
                     state    <= EMPTY;
                     tx_valid <= 1'b0;
                  end
               end
               default: begin
                  state    <= EMPTY;
                  tx_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_ram_cmd.sv
// tb_spi_ram_cmd: directed vector table for spi_ram_cmd plus hand-written
// sequences for the long HOLD idle and the reset-drops-write corner.
module tb_spi_ram_cmd;

   logic       clk;
   logic       rst;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;
   logic       seq_err;

   int checks;
   int errors;

   typedef struct {
      logic       rst;
      logic       rv;
      logic [9:0] din;
      logic       tv;
      logic [7:0] dout;
      logic       se;
   } vec_t;

   vec_t vec_a[$];
   vec_t vec_b[$];

   spi_ram_cmd #(
      .MEM_DEPTH(256),
      .ADDR_SIZE(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .rx_valid(rx_valid),
      .dout(dout),
      .tx_valid(tx_valid),
      .seq_err(seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h required=%02h", name, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic r, input logic rv, input logic [9:0] d);
      @(negedge clk);
      rst      = r;
      rx_valid = rv;
      din      = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic tv, input logic [7:0] d, input logic se);
      cmp($sformatf("%s tx_valid", tag), {7'd0, tx_valid}, {7'd0, tv});
      cmp($sformatf("%s dout", tag), dout, d);
      cmp($sformatf("%s seq_err", tag), {7'd0, seq_err}, {7'd0, se});
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      step(v.rst, v.rv, v.din);
      check_all(tag, v.tv, v.dout, v.se);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      rx_valid = 1'b0;
      din      = '0;

      //                rst  rv    din     tv    dout  se
      vec_a.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0}); // reset state
      vec_a.push_back('{1'b0, 1'b1, 10'h300, 1'b0, 8'h00, 1'b1}); // RD_DATA w/o pointer
      vec_a.push_back('{1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0}); // seq_err drops
      vec_a.push_back('{1'b0, 1'b1, 10'h012, 1'b0, 8'h00, 1'b0}); // WR_ADDR 12
      vec_a.push_back('{1'b0, 1'b1, 10'h1A5, 1'b0, 8'h00, 1'b0}); // mem[12]=A5
      vec_a.push_back('{1'b0, 1'b1, 10'h15A, 1'b0, 8'h00, 1'b0}); // mem[13]=5A
      vec_a.push_back('{1'b0, 1'b1, 10'h177, 1'b0, 8'h00, 1'b0}); // mem[14]=77
      vec_a.push_back('{1'b0, 1'b1, 10'h212, 1'b0, 8'h00, 1'b0}); // RD_ADDR 12
      vec_a.push_back('{1'b0, 1'b1, 10'h300, 1'b1, 8'hA5, 1'b0});
      vec_a.push_back('{1'b0, 1'b1, 10'h300, 1'b1, 8'h5A, 1'b0});
      vec_a.push_back('{1'b0, 1'b1, 10'h300, 1'b1, 8'h77, 1'b0}); // rd_ptr had reached 14
      vec_a.push_back('{1'b0, 1'b1, 10'h0FF, 1'b0, 8'h77, 1'b0}); // WR_ADDR FF releases HOLD
      vec_a.push_back('{1'b0, 1'b1, 10'h111, 1'b0, 8'h77, 1'b0}); // mem[FF]=11
      vec_a.push_back('{1'b0, 1'b1, 10'h122, 1'b0, 8'h77, 1'b0}); // wrap, mem[00]=22
      vec_a.push_back('{1'b0, 1'b1, 10'h2FF, 1'b0, 8'h77, 1'b0}); // RD_ADDR FF
      vec_a.push_back('{1'b0, 1'b1, 10'h300, 1'b1, 8'h11, 1'b0});
      vec_a.push_back('{1'b0, 1'b1, 10'h300, 1'b1, 8'h22, 1'b0}); // read wraps to 0

      vec_b.push_back('{1'b0, 1'b1, 10'h000, 1'b0, 8'h22, 1'b0}); // WR_ADDR 0 releases HOLD
      vec_b.push_back('{1'b0, 1'b0, 10'h1FF, 1'b0, 8'h22, 1'b0}); // no rx_valid: ignored
      vec_b.push_back('{1'b0, 1'b1, 10'h005, 1'b0, 8'h22, 1'b0}); // WR_ADDR 5
      vec_b.push_back('{1'b0, 1'b1, 10'h205, 1'b0, 8'h22, 1'b0}); // RD_ADDR 5
      vec_b.push_back('{1'b0, 1'b1, 10'h1C3, 1'b0, 8'h22, 1'b0}); // mem[5]=C3
      vec_b.push_back('{1'b0, 1'b1, 10'h300, 1'b1, 8'hC3, 1'b0}); // read right after write
      vec_b.push_back('{1'b0, 1'b1, 10'h003, 1'b0, 8'hC3, 1'b0}); // WR_ADDR 3
      vec_b.push_back('{1'b0, 1'b1, 10'h1AB, 1'b0, 8'hC3, 1'b0}); // mem[3]=AB
      vec_b.push_back('{1'b0, 1'b1, 10'h203, 1'b0, 8'hC3, 1'b0}); // RD_ADDR 3
      vec_b.push_back('{1'b0, 1'b1, 10'h300, 1'b1, 8'hAB, 1'b0}); // HOLD with AB
      vec_b.push_back('{1'b0, 1'b1, 10'h003, 1'b0, 8'hAB, 1'b0}); // WR_ADDR 3 again

      foreach (vec_a[i]) run_vec($sformatf("vecA%0d", i), vec_a[i]);

      // HOLD persists across a long idle stretch with dout stable.
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 10'h300);
         check_all($sformatf("idle%0d", i), 1'b1, 8'h22, 1'b0);
      end

      foreach (vec_b[i]) run_vec($sformatf("vecB%0d", i), vec_b[i]);

      // Reset on the same edge as a WR_DATA to loaded address 3: the write is dropped.
      step(1'b1, 1'b1, 10'h1FF);
      check_all("rst_wr", 1'b0, 8'h00, 1'b0);
      // Flags were cleared: a WR_DATA now is rejected.
      step(1'b0, 1'b1, 10'h1FF);
      check_all("rej_wr", 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b1, 10'h003);
      check_all("reload_wr", 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 10'h203);
      check_all("reload_rd", 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 10'h300);
      check_all("prior_data", 1'b1, 8'hAB, 1'b0);

      // Reset mid-read clears tx_valid at that edge.
      step(1'b1, 1'b1, 10'h300);
      check_all("rst_hold", 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 10'h000);
      check_all("post_rst", 1'b0, 8'h00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
